// File: rtl/hack_cpu_pkg.sv
// Shared types and instruction field positions for the Hack-derived CPU control stage.
package hack_cpu_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    MREAD  = 3'd2,
    EXEC   = 3'd3,
    MWRITE = 3'd4
  } state_t;

  localparam int CI_BIT  = 15;
  localparam int SEL_HI  = 14;
  localparam int SEL_LO  = 13;
  localparam int A_BIT   = 12;
  localparam int FN_HI   = 14;
  localparam int FN_LO   = 6;
  localparam int DEST_A  = 5;
  localparam int DEST_D  = 4;
  localparam int DEST_M  = 3;
  localparam int JUMP_HI = 2;
  localparam int JUMP_LO = 0;

  localparam logic [1:0] SEL_STD   = 2'b11;
  localparam logic [1:0] SEL_SHIFT = 2'b01;

  // Selectors other than STD/SHIFT decode to a NOP.
  function automatic logic is_alu_op(input logic [15:0] instr);
    return (instr[SEL_HI:SEL_LO] == SEL_STD) || (instr[SEL_HI:SEL_LO] == SEL_SHIFT);
  endfunction

endpackage

// File: rtl/hack_jump_unit.sv
// Jump condition evaluation from the j1/j2/j3 bits and the ALU flags.
module hack_jump_unit (
  input  logic [2:0] j,
  input  logic       zr,
  input  logic       ng,
  output logic       take
);

  assign take = (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);

endmodule

// File: rtl/hack_cpu_control.sv
// Multi-cycle fetch/decode/execute control with A, D and PC registers around an external ALU.
module hack_cpu_control
  import hack_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [14:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_valid,
  output logic        dmem_rd,
  output logic        dmem_wr,
  output logic [14:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [8:0]  alu_instr,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng,
  output logic [14:0] pc,
  output logic        retire
);

  state_t      state_reg;
  logic [15:0] instr_reg;
  logic [15:0] a_reg;
  logic [15:0] d_reg;
  logic        jump_take;
  logic        simple_instr;

  hack_jump_unit u_jump (
    .j    (instr_reg[JUMP_HI:JUMP_LO]),
    .zr   (alu_zr),
    .ng   (alu_ng),
    .take (jump_take)
  );

  // A-instructions and NOPs finish in DECODE without touching the ALU.
  assign simple_instr = ~instr_reg[CI_BIT] | ~is_alu_op(instr_reg);
  assign imem_addr    = pc;
  assign retire = ((state_reg == DECODE) & simple_instr) |
                  ((state_reg == EXEC) & ~instr_reg[DEST_M]) |
                  ((state_reg == MWRITE) & dmem_ack);

  // alu_y doubles as the M latch: it is loaded from dmem_rdata on the way into EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= FETCH;
      instr_reg  <= '0;
      a_reg      <= '0;
      d_reg      <= '0;
      pc         <= '0;
      imem_req   <= 1'b0;
      dmem_rd    <= 1'b0;
      dmem_wr    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      alu_x      <= '0;
      alu_y      <= '0;
      alu_instr  <= '0;
    end else begin
      case (state_reg)
        FETCH: begin
          imem_req <= 1'b1;
          if (imem_req && imem_valid) begin
            instr_reg <= imem_data;
            imem_req  <= 1'b0;
            state_reg <= DECODE;
          end
        end
        DECODE: begin
          if (simple_instr) begin
            if (!instr_reg[CI_BIT]) a_reg <= {1'b0, instr_reg[14:0]};
            pc        <= pc + 15'd1;
            imem_req  <= 1'b1;
            state_reg <= FETCH;
          end else if (instr_reg[A_BIT]) begin
            dmem_rd   <= 1'b1;
            dmem_addr <= a_reg[14:0];
            state_reg <= MREAD;
          end else begin
            alu_x     <= d_reg;
            alu_y     <= a_reg;
            alu_instr <= instr_reg[FN_HI:FN_LO];
            state_reg <= EXEC;
          end
        end
        MREAD: begin
          if (dmem_ack) begin
            dmem_rd   <= 1'b0;
            alu_x     <= d_reg;
            alu_y     <= dmem_rdata;
            alu_instr <= instr_reg[FN_HI:FN_LO];
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          // Jump target and store address both use A as it was before this writeback.
          if (instr_reg[DEST_A]) a_reg <= alu_out;
          if (instr_reg[DEST_D]) d_reg <= alu_out;
          pc <= jump_take ? a_reg[14:0] : pc + 15'd1;
          if (instr_reg[DEST_M]) begin
            dmem_wr    <= 1'b1;
            dmem_addr  <= a_reg[14:0];
            dmem_wdata <= alu_out;
            state_reg  <= MWRITE;
          end else begin
            imem_req  <= 1'b1;
            state_reg <= FETCH;
          end
        end
        MWRITE: begin
          if (dmem_ack) begin
            dmem_wr   <= 1'b0;
            imem_req  <= 1'b1;
            state_reg <= FETCH;
          end
        end
        default: begin
          state_reg <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hack_cpu_control.sv
// Directed bench for hack_cpu_control with a behavioural ALU and single-cycle memory responders.
module tb_hack_cpu_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [14:0] imem_addr;
  logic [15:0] imem_data = '0;
  logic        imem_valid = 1'b0;
  logic        dmem_rd, dmem_wr;
  logic [14:0] dmem_addr;
  logic [15:0] dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic [15:0] alu_x, alu_y, alu_out;
  logic [8:0]  alu_instr;
  logic        alu_zr, alu_ng;
  logic [14:0] pc;
  logic        retire;

  int checks = 0, errors = 0;
  int cyc = 0, retire_cnt = 0, wr_count = 0, rd_count = 0;
  logic [14:0] last_wr_addr = '0, last_rd_addr = '0;
  logic [15:0] last_wr_data = '0;
  logic        dack_en = 1'b1;
  logic [15:0] mem_val = '0;

  hack_cpu_control dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data), .imem_valid(imem_valid),
    .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .alu_x(alu_x), .alu_y(alu_y), .alu_instr(alu_instr), .alu_out(alu_out),
    .alu_zr(alu_zr), .alu_ng(alu_ng), .pc(pc), .retire(retire)
  );

  always #5 clk = ~clk;

  assign dmem_ack   = (dmem_rd | dmem_wr) & dack_en;
  assign dmem_rdata = mem_val;

  // Behavioural ALU: classic Hack ALU for the standard selector, x<<1 for the shift selector.
  logic [15:0] bx, by, bres;
  always_comb begin
    bx = alu_x;
    by = alu_y;
    bres = 16'h0000;
    if (alu_instr[8:7] == 2'b01) begin
      bres = alu_x << 1;
    end else begin
      if (alu_instr[5]) bx = 16'h0000;
      if (alu_instr[4]) bx = ~bx;
      if (alu_instr[3]) by = 16'h0000;
      if (alu_instr[2]) by = ~by;
      bres = alu_instr[1] ? (bx + by) : (bx & by);
      if (alu_instr[0]) bres = ~bres;
    end
  end
  assign alu_out = bres;
  assign alu_zr  = (bres == 16'h0000);
  assign alu_ng  = bres[15];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (retire) retire_cnt <= retire_cnt + 1;
    if (dmem_wr && dmem_ack) begin
      wr_count     <= wr_count + 1;
      last_wr_addr <= dmem_addr;
      last_wr_data <= dmem_wdata;
    end
    if (dmem_rd && dmem_ack) begin
      rd_count     <= rd_count + 1;
      last_rd_addr <= dmem_addr;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (int'(imem_req) + int'(dmem_rd) + int'(dmem_wr) > 1) begin
        errors++;
        $display("FAIL req_exclusive: imem_req=%b dmem_rd=%b dmem_wr=%b, required at most one high",
                 imem_req, dmem_rd, dmem_wr);
      end
    end
  end

  task automatic do_fetch(input logic [15:0] ins, input int delay, output int start);
    logic [14:0] addr0;
    int n = 0;
    while (!imem_req && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL fetch_req: imem_req=%b after %0d cycles, required 1", imem_req, n);
    end
    start = cyc;
    addr0 = imem_addr;
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); #1;
      checks++;
      if (imem_addr !== addr0 || imem_req !== 1'b1) begin
        errors++;
        $display("FAIL fetch_hold: imem_req=%b imem_addr=%h, required 1 and %h", imem_req, imem_addr, addr0);
      end
    end
    imem_data  = ins;
    imem_valid = 1'b1;
    @(posedge clk); #1;
    imem_valid = 1'b0;
  endtask

  task automatic run(input logic [15:0] ins, input int delay, output int lat);
    int r0, start;
    int n = 0;
    r0 = retire_cnt;
    do_fetch(ins, delay, start);
    while (retire_cnt == r0 && n < 30) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (retire_cnt != r0 + 1) begin
      errors++;
      $display("FAIL retire_wait: instr %h retire count delta %0d, required 1", ins, retire_cnt - r0);
    end
    lat = cyc - start;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({imem_req, dmem_rd, dmem_wr, retire, pc, alu_instr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b rd=%b wr=%b retire=%b pc=%h alu_instr=%h, required all 0",
               imem_req, dmem_rd, dmem_wr, retire, pc, alu_instr);
    end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 15'h0000) begin
      errors++;
      $display("FAIL reset_release: imem_req=%b imem_addr=%h, required 1 and 0000", imem_req, imem_addr);
    end
  endtask

  task automatic probe_d(input logic [15:0] exp, input string name);
    int lat;
    run(16'hE308, 0, lat);
    checks++;
    if (last_wr_data !== exp) begin
      errors++;
      $display("FAIL %s: D observed %h, required %h", name, last_wr_data, exp);
    end
  endtask

  task automatic test_program();
    int l1, l2, r0;
    r0 = retire_cnt;
    run(16'h0005, 0, l1);
    run(16'hEC10, 0, l2);
    checks++;
    if (l1 + l2 != 5 || l1 != 2) begin
      errors++;
      $display("FAIL prog_latency: cycles %0d+%0d, required 2+3", l1, l2);
    end
    checks++;
    if (pc !== 15'd2 || retire_cnt - r0 != 2) begin
      errors++;
      $display("FAIL prog_state: pc=%h retires=%0d, required 0002 and 2", pc, retire_cnt - r0);
    end
    probe_d(16'd5, "prog_d");
  endtask

  task automatic test_store();
    int lat, rd0, wr0;
    run(16'd7, 0, lat);
    run(16'hEC10, 0, lat);
    run(16'd100, 0, lat);
    rd0 = rd_count; wr0 = wr_count;
    run(16'hE7C8, 0, lat);
    checks++;
    if (wr_count != wr0 + 1 || last_wr_addr !== 15'd100 || last_wr_data !== 16'd8) begin
      errors++;
      $display("FAIL store: writes=%0d addr=%0d data=%0d, required 1, 100, 8",
               wr_count - wr0, last_wr_addr, last_wr_data);
    end
    checks++;
    if (rd_count != rd0 || lat != 4) begin
      errors++;
      $display("FAIL store_timing: reads=%0d cycles=%0d, required 0 and 4", rd_count - rd0, lat);
    end
  endtask

  task automatic test_read_modify();
    int lat;
    run(16'd3, 0, lat);
    mem_val = 16'd10;
    run(16'hFCA8, 0, lat);
    checks++;
    if (last_rd_addr !== 15'd3 || last_wr_addr !== 15'd3 || last_wr_data !== 16'd9 || lat != 5) begin
      errors++;
      $display("FAIL am_m_minus1: rd_addr=%0d wr_addr=%0d data=%0d cycles=%0d, required 3, 3, 9, 5",
               last_rd_addr, last_wr_addr, last_wr_data, lat);
    end
    run(16'hEC08, 0, lat);
    checks++;
    if (last_wr_addr !== 15'd9 || last_wr_data !== 16'd9) begin
      errors++;
      $display("FAIL am_new_a: A observed addr=%0d data=%0d, required 9", last_wr_addr, last_wr_data);
    end
  endtask

  task automatic test_jumps();
    int lat;
    logic [14:0] p;
    run(16'h0000, 0, lat);
    run(16'hEC10, 0, lat);
    run(16'h1234, 0, lat);
    run(16'hE302, 0, lat);
    checks++;
    if (pc !== 15'h1234) begin
      errors++;
      $display("FAIL jeq_taken: pc=%h, required 1234", pc);
    end
    run(16'h0005, 0, lat);
    run(16'hEC10, 0, lat);
    p = pc;
    run(16'hE304, 0, lat);
    checks++;
    if (pc !== p + 15'd1) begin
      errors++;
      $display("FAIL jlt_not_taken: pc=%h, required %h", pc, p + 15'd1);
    end
    run(16'h7FFF, 0, lat);
    run(16'hEA87, 0, lat);
    checks++;
    if (pc !== 15'h7FFF) begin
      errors++;
      $display("FAIL jmp_uncond: pc=%h, required 7fff", pc);
    end
    run(16'h0000, 0, lat);
    checks++;
    if (pc !== 15'h0000) begin
      errors++;
      $display("FAIL pc_wrap: pc=%h, required 0000", pc);
    end
  endtask

  task automatic test_shift();
    int lat;
    run(16'd7, 0, lat);
    run(16'hEC10, 0, lat);
    run(16'hAC10, 0, lat);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL shift_latency: cycles=%0d, required 3", lat);
    end
    probe_d(16'd14, "shift_d");
  endtask

  task automatic test_nop();
    int lat, rd0, wr0;
    logic [14:0] p;
    run(16'd21, 0, lat);
    run(16'hEC10, 0, lat);
    p = pc; rd0 = rd_count; wr0 = wr_count;
    run(16'h8000, 0, lat);
    checks++;
    if (pc !== p + 15'd1 || lat != 2 || rd_count != rd0 || wr_count != wr0) begin
      errors++;
      $display("FAIL nop: pc=%h cycles=%0d reads=%0d writes=%0d, required %h, 2, 0, 0",
               pc, lat, rd_count - rd0, wr_count - wr0, p + 15'd1);
    end
    probe_d(16'd21, "nop_d_kept");
  endtask

  task automatic test_fetch_wait();
    int lat;
    run(16'h0005, 3, lat);
    checks++;
    if (lat != 5) begin
      errors++;
      $display("FAIL fetch_wait_latency: cycles=%0d, required 5", lat);
    end
  endtask

  task automatic test_reset_mid_mread();
    int start;
    int lat;
    run(16'd3, 0, lat);
    dack_en = 1'b0;
    do_fetch(16'hFCA8, 0, start);
    @(posedge clk); #1;
    checks++;
    if (dmem_rd !== 1'b1 || dmem_addr !== 15'd3) begin
      errors++;
      $display("FAIL mread_pending: dmem_rd=%b addr=%0d, required 1 and 3", dmem_rd, dmem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_req, dmem_rd, dmem_wr, retire, dmem_addr, dmem_wdata, alu_x, alu_y, alu_instr, pc} !== '0) begin
      errors++;
      $display("FAIL reset_mid_mread: req=%b rd=%b wr=%b addr=%h alu_y=%h pc=%h, required all 0",
               imem_req, dmem_rd, dmem_wr, dmem_addr, alu_y, pc);
    end
    dack_en = 1'b1;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 15'h0000) begin
      errors++;
      $display("FAIL reset_mid_release: imem_req=%b imem_addr=%h, required 1 and 0000", imem_req, imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_store();
    test_read_modify();
    test_jumps();
    test_shift();
    test_nop();
    test_fetch_wait();
    test_reset_mid_mread();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
